// File: rtl/result_sender.sv
// Streams a latched ASCII result buffer to a UART transmitter one byte at a time, skipping NULs.
// Define RESULT_SENDER_CRLF_EN to append a CR/LF terminator after the buffer.
module result_sender #(
    parameter int NBYTES = 16,
    parameter int CW     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                out_en,
    input  logic [8*NBYTES-1:0] result,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    output logic                sent,
    output logic [CW-1:0]       byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_CR_LF,
        S_FINISH
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES);
`ifdef RESULT_SENDER_CRLF_EN
    localparam logic [CW-1:0] LF_IDX   = CW'(NBYTES + 1);
`endif

    state_t            state_reg, state_next;
    logic [CW-1:0]     index_reg, index_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              tx_start_reg, tx_start_next;
    logic              sent_reg, sent_next;
    logic [CW-1:0]     byte_cnt_reg, byte_cnt_next;
    logic              latch_en;
    logic [8*NBYTES-1:0] buf_flat;
    logic [7:0]        cur_byte;

    // Character gi lives in its own register; char 0 is the MSB byte of result.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_buf
            logic [7:0] char_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    char_reg <= '0;
                else if (latch_en)
                    char_reg <= result[8*(NBYTES-gi)-1 -: 8];
            end
            assign buf_flat[8*gi +: 8] = char_reg;
        end
    endgenerate

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (index_reg == CW'(i))
                cur_byte = buf_flat[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            index_reg    <= '0;
            tx_data_reg  <= 8'h00;
            tx_start_reg <= 1'b0;
            sent_reg     <= 1'b0;
            byte_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            sent_reg     <= sent_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        sent_next     = sent_reg;
        byte_cnt_next = byte_cnt_reg;
        latch_en      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                sent_next = 1'b0;
                if (out_en) begin
                    latch_en      = 1'b1;
                    index_next    = '0;
                    byte_cnt_next = '0;
                    state_next    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!out_en) begin
                    state_next = S_IDLE;
                end else if (index_reg >= LAST_IDX) begin
`ifdef RESULT_SENDER_CRLF_EN
                    state_next = S_CR_LF;
`else
                    state_next = S_FINISH;
                    sent_next  = 1'b1;
`endif
                end else if (cur_byte == 8'h00) begin
                    index_next = index_reg + CW'(1);
                end else begin
                    tx_data_next = cur_byte;
                    state_next   = S_ISSUE;
                end
            end

`ifdef RESULT_SENDER_CRLF_EN
            // Terminator bytes reuse the index past the buffer end.
            S_CR_LF: begin
                if (!out_en) begin
                    state_next = S_IDLE;
                end else if (index_reg == LAST_IDX) begin
                    tx_data_next = 8'h0D;
                    state_next   = S_ISSUE;
                end else if (index_reg == LF_IDX) begin
                    tx_data_next = 8'h0A;
                    state_next   = S_ISSUE;
                end else begin
                    state_next = S_FINISH;
                    sent_next  = 1'b1;
                end
            end
`endif

            S_ISSUE: begin
                if (!out_en) begin
                    state_next = S_IDLE;
                end else if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    state_next    = S_ACK;
                end
            end

            // A frame is in flight from here on, so out_en is only honoured once it ends.
            S_ACK: begin
                if (tx_busy)
                    state_next = S_DRAIN;
            end

            S_DRAIN: begin
                if (!tx_busy) begin
                    if (byte_cnt_reg != '1)
                        byte_cnt_next = byte_cnt_reg + CW'(1);
                    index_next = index_reg + CW'(1);
                    state_next = out_en ? S_FETCH : S_IDLE;
                end
            end

            S_FINISH: begin
                if (!out_en) begin
                    sent_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;
    assign sent     = sent_reg;
    assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_result_sender.sv
// Scoreboard bench for result_sender: stimulus queues expected bytes, a monitor checks each tx_start.
// Follows RESULT_SENDER_CRLF_EN so the same vectors work in either build.
module tb_result_sender;
    localparam int NBYTES = 16;
    localparam int CW     = 5;
`ifdef RESULT_SENDER_CRLF_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                out_en = 1'b0;
    logic [8*NBYTES-1:0] result = '0;
    logic                tx_busy;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                sent;
    logic [CW-1:0]       byte_cnt;

    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         sent_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_start = 1'b0;

    result_sender #(.NBYTES(NBYTES), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .out_en   (out_en),
        .result   (result),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .sent     (sent),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles after each accepted strobe.
    assign tx_busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start)
            busy_cnt <= 10;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sent)
            sent_cnt++;
        if (rst_n && tx_start) begin
            if (prev_start) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL tx_start_width: strobe high two cycles in a row, expected one");
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_tx_start: got byte %0h, expected no transmission", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, mon_exp});
                $display("[TB] tx byte %02h (expected %02h)", tx_data, mon_exp);
            end
        end
        prev_start = tx_start;
    end

    task automatic push_bytes(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(s[63-8*i -: 8]);
    endtask

    task automatic push_crlf();
`ifdef RESULT_SENDER_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic wait_sent(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            cycles++;
            #1;
            if (sent) break;
        end
        check("sent_reached", {31'h0, sent}, 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k = 0;
        int c = 0;
        while (k < target && c < budget) begin
            @(negedge clk);
            c++;
            if (tx_start) k++;
        end
        check("strobe_count_reached", k, target);
    endtask

    initial begin
        int cyc;
        int s0;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx_start", {31'h0, tx_start}, 32'd0);
        check("reset_sent", {31'h0, sent}, 32'd0);
        check("reset_byte_cnt", {27'h0, byte_cnt}, 32'd0);
        check("reset_tx_data", {24'h0, tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Leading NULs then "   12345"; buffer altered after the latch must not matter
        result = {64'h0, 64'("   12345")};
        push_bytes("   12345", 8);
        push_crlf();
        out_en = 1'b1;
        repeat (2) @(negedge clk);
        result = {NBYTES{8'h58}};
        wait_sent(2000, cyc);
        check("main_byte_cnt", {27'h0, byte_cnt}, 8 + EXTRA);
        check("main_queue_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        check("main_sent_held", {31'h0, sent}, 32'd1);
        out_en = 1'b0;
        @(posedge clk);
        #1;
        check("main_sent_drop", {31'h0, sent}, 32'd0);
        $display("[TB] main message done, byte_cnt=%0d", byte_cnt);
        repeat (15) @(negedge clk);

        // All-NUL buffer
        result = '0;
        push_crlf();
        out_en = 1'b1;
        wait_sent(500, cyc);
`ifndef RESULT_SENDER_CRLF_EN
        check("allnul_sent_latency", cyc, 18);
`endif
        check("allnul_byte_cnt", {27'h0, byte_cnt}, EXTRA);
        check("allnul_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        out_en = 1'b0;
        $display("[TB] all-NUL message done, cycles=%0d", cyc);
        repeat (15) @(negedge clk);

        // Transmitter busy for 50 cycles when out_en rises
        result = {16'h4142, 112'h0};
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        push_crlf();
        force_busy = 1'b1;
        out_en = 1'b1;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start) k++;
        end
        check("busy_no_strobe", k, 0);
        force_busy = 1'b0;
        wait_sent(1000, cyc);
        check("busy_byte_cnt", {27'h0, byte_cnt}, 2 + EXTRA);
        check("busy_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        out_en = 1'b0;
        $display("[TB] busy-hold message done, byte_cnt=%0d", byte_cnt);
        repeat (15) @(negedge clk);

        // Abort while in ACK on the third byte
        result = {48'h414243444546, 80'h0};
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        s0 = sent_cnt;
        out_en = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (tx_start) break;
        end
        check("first_strobe_latency", cyc, 3);
        @(negedge clk);
        wait_strobes(2, 500);
        out_en = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_byte_cnt", {27'h0, byte_cnt}, 32'd3);
        check("abort_queue_drained", exp_q.size(), 0);
        check("abort_sent_never", sent_cnt - s0, 0);
        check("abort_sent_low", {31'h0, sent}, 32'd0);
        $display("[TB] abort message done, byte_cnt=%0d", byte_cnt);

        // Reset asserted mid-DRAIN, then a fresh message from char 0
        result = {64'h0, 64'("   12345")};
        push_bytes("   12345", 8);
        push_crlf();
        out_en = 1'b1;
        wait_strobes(2, 500);
        repeat (4) @(negedge clk);
        check("pre_reset_byte_cnt", {27'h0, byte_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx_start", {31'h0, tx_start}, 32'd0);
        check("async_reset_sent", {31'h0, sent}, 32'd0);
        check("async_reset_byte_cnt", {27'h0, byte_cnt}, 32'd0);
        exp_q.delete();
        out_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        push_bytes("   12345", 8);
        push_crlf();
        out_en = 1'b1;
        wait_sent(2000, cyc);
        check("restart_byte_cnt", {27'h0, byte_cnt}, 8 + EXTRA);
        check("restart_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        out_en = 1'b0;
        $display("[TB] restart message done, byte_cnt=%0d", byte_cnt);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
